// File: rtl/pic_screen_fetch.sv
// Full-screen picture fetch: maps the VGA raster onto a 320x240 picture shown 2x scaled,
// selects the picture for the current scene (with two-phase title/lose animations) and
// realigns the ROM read data with the delayed valid. Raster to vga_rgb latency is 3 clocks.
module pic_screen_fetch #(
   parameter int unsigned IMG_W       = 320,
   parameter int unsigned IMG_H       = 240,
   parameter int unsigned ANIM_FRAMES = 30
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        valid,
   input  logic [1:0]  scene,
   output logic [16:0] addr,
   input  logic [11:0] pix_sco,
   input  logic [11:0] pix_ti1,
   input  logic [11:0] pix_ti2,
   input  logic [11:0] pix_en1,
   input  logic [11:0] pix_en2,
   input  logic [11:0] pix_win,
   output logic [11:0] vga_rgb,
   output logic        rgb_valid
);

   localparam int unsigned CntW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ANIM_FRAMES - 1);

   typedef enum logic [1:0] {
      SceneTitle = 2'd0,
      SceneScore = 2'd1,
      SceneLose  = 2'd2,
      SceneWin   = 2'd3
   } scene_e;

   typedef enum logic [2:0] {
      PicSco = 3'd0,
      PicTi1 = 3'd1,
      PicTi2 = 3'd2,
      PicEn1 = 3'd3,
      PicEn2 = 3'd4,
      PicWin = 3'd5
   } pic_e;

   // Scene / animation state
   scene_e          scene_q, scene_d;
   logic            phase_q, phase_d;
   logic [CntW-1:0] fcnt_q, fcnt_d;
   logic            frame_tick;

   // Pipeline
   logic [16:0] addr_d;
   logic        in_area;
   logic [16:0] row_base;
   logic [16:0] col_off;
   pic_e        pic_d;
   logic        valid_s1, valid_s2;
   pic_e        pic_s1, pic_s2;
   logic [11:0] pix_sel;
   logic [11:0] rgb_d;

   assign frame_tick = (h_cnt == 10'd0) && (v_cnt == 10'd0);

   // Frame tick bookkeeping: scene latches only at frame start, counter/phase advance per frame
   always_comb begin
      scene_d = scene_q;
      phase_d = phase_q;
      fcnt_d  = fcnt_q;
      if (frame_tick) begin
         if (scene_e'(scene) != scene_q) begin
            scene_d = scene_e'(scene);
            phase_d = 1'b0;
            fcnt_d  = '0;
         end else if (fcnt_q == CntLast) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d  = fcnt_q + 1'b1;
         end
      end
   end

   // Scene / animation state register
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         scene_q <= SceneTitle;
         phase_q <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         scene_q <= scene_d;
         phase_q <= phase_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Picture select; uses next-state values so a tick's update applies to that first pixel
   always_comb begin
      pic_d = PicSco;
      unique case (scene_d)
         SceneTitle: pic_d = phase_d ? PicTi2 : PicTi1;
         SceneScore: pic_d = PicSco;
         SceneLose:  pic_d = phase_d ? PicEn2 : PicEn1;
         SceneWin:   pic_d = PicWin;
         default:    pic_d = PicSco;
      endcase
   end

   // Raster to ROM address: halve both coordinates for the 2x scaling
   always_comb begin
      in_area  = valid && (32'(h_cnt) < 2 * IMG_W) && (32'(v_cnt) < 2 * IMG_H);
      row_base = 17'(v_cnt[9:1]) * 17'(IMG_W);
      col_off  = 17'(h_cnt[9:1]);
      addr_d   = in_area ? (row_base + col_off) : 17'd0;
   end

   // Stage 1: address to ROMs, valid and select
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         addr     <= 17'd0;
         valid_s1 <= 1'b0;
         pic_s1   <= PicSco;
      end else begin
         addr     <= addr_d;
         valid_s1 <= valid;
         pic_s1   <= pic_d;
      end
   end

   // Stage 2: match the one-cycle ROM read latency
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         valid_s2 <= 1'b0;
         pic_s2   <= PicSco;
      end else begin
         valid_s2 <= valid_s1;
         pic_s2   <= pic_s1;
      end
   end

   // ROM data mux, blanked outside the active area
   always_comb begin
      pix_sel = 12'h000;
      unique case (pic_s2)
         PicSco:  pix_sel = pix_sco;
         PicTi1:  pix_sel = pix_ti1;
         PicTi2:  pix_sel = pix_ti2;
         PicEn1:  pix_sel = pix_en1;
         PicEn2:  pix_sel = pix_en2;
         PicWin:  pix_sel = pix_win;
         default: pix_sel = 12'h000;
      endcase
      rgb_d = valid_s2 ? pix_sel : 12'h000;
   end

   // Stage 3: registered RGB to the pins
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         vga_rgb   <= 12'h000;
         rgb_valid <= 1'b0;
      end else begin
         vga_rgb   <= rgb_d;
         rgb_valid <= valid_s2;
      end
   end

endmodule
